data_check: RTL and testbench
=============================

# data_check

Receive-side checker for the channel test-pattern stream. It sits at the far end of the capture path from the per-channel pattern generator. It accepts AXI4-Stream beats and verifies the replicated 16-bit incrementing pattern, TKEEP and packet framing. It exposes beat, packet and error counters plus first-error capture to software and debug.

## Interface
- DW, 512: stream data width in bits; must be a multiple of 16.
- CHANNEL, 0: channel number; sets the seed of the expected pattern to (CHANNEL<<8)|CHANNEL, 16 bits.
- PKT_BEATS, 8: beats per packet; must be a power of 2, at least 2.

Ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of counters, the sticky flag and the first-error capture.
- pause  in  1  requests backpressure; AXIS_IN_TREADY follows ~pause, one cycle late.
- AXIS_IN_TDATA  in  DW  pattern data; DW/16 lanes of 16 bits.
- AXIS_IN_TKEEP  in  DW/8  must be all-ones.
- AXIS_IN_TLAST  in  1  end of packet.
- AXIS_IN_TVALID  in  1  beat valid.
- AXIS_IN_TREADY  out  1  registered ready.
- beat_count  out  32  accepted beats, wraps.
- packet_count  out  32  accepted beats with TLAST=1, wraps.
- data_errors  out  16  beats with a lane or TKEEP mismatch; saturates at 0xFFFF.
- framing_errors  out  16  beats with a TLAST mismatch; saturates at 0xFFFF.
- error  out  1  sticky; set by any data or framing error.
- first_bad_expected  out  16  expected value at the first data error.
- first_bad_received  out  16  value of the lowest-indexed mismatching lane at the first data error; 0xFFFF if only TKEEP was bad.

## Operation
- Accept: a beat is accepted when AXIS_IN_TVALID & AXIS_IN_TREADY. Nothing changes on non-accepted cycles.
- Internal state:
  - expected, 16 bits.
  - beat_idx, log2(PKT_BEATS) bits.
  - FSM with states RESET and RUN.
- FSM:
  - reset asserted forces RESET. In RESET, TREADY=0.
  - On the first clk edge after reset deasserts, the FSM moves to RESET→RUN.
  - In RUN, TREADY is registered as ~pause.
- Data check, per accepted beat:
  - Every lane must equal expected.
  - TKEEP must be all-ones.
  - Either failure increments data_errors by exactly 1.
- Resync: on every accepted beat, expected <= lane0 + 1, mod 2^16. This is identical to expected+1 on a good beat. After a skip or corruption of lane 0, checking resumes from the received value, so one bad beat produces exactly one error.
- Framing check: TLAST must equal (beat_idx == PKT_BEATS-1). A mismatch increments framing_errors.
- beat_idx update:
  - If TLAST=1, beat_idx <= 0. An early TLAST therefore resyncs to the packet boundary.
  - Otherwise beat_idx <= beat_idx + 1, wrapping. A missing TLAST therefore wraps to 0 and is flagged once.
- First error: first_bad_* is loaded on a data error only while data_errors == 0.
- A single beat can fail both checks; both counters increment.
- clear asserted together with an accepted beat:
  - Counters, error and first_bad_* end at 0; that beat's contribution is discarded.
  - expected and beat_idx still advance.
- Reset values:
  - AXIS_IN_TREADY=0, counters=0, error=0, first_bad_*=0.
  - expected=(CHANNEL<<8)|CHANNEL, beat_idx=0.

## Timing
- All outputs are registered.
- Counters, error and first_bad_* reflect an accepted beat in the cycle after the accepting edge.
- TREADY rises one cycle after reset deasserts if pause=0.
- A pause edge takes effect on TREADY one cycle later. The source must tolerate one extra accepted beat after pause rises.
- Async reset mid-packet returns to the full reset state immediately. The next packet must restart at the seed with beat_idx 0.
- Data-check logic is combinational across the DW/16 lanes with a single register stage. No pipeline latency is added to TREADY.

## Test plan
- Clean stream: CHANNEL=3, 16 beats starting at 0x0303, TLAST on beats 7 and 15. Expect beat_count=16, packet_count=2, both error counters 0, error=0.
- Lane corruption: beat 3, lane 5 = 0x0307 (expected 0x0306), lane 0 intact. Expect data_errors=1, first_bad_expected=0x0306, first_bad_received=0x0307, error=1; later beats produce no errors.
- Skip: send 0x0305 where 0x0304 is expected, then 0x0306 onward. Expect data_errors=1 only.
- Framing: TLAST on beat 5, then a normal 8-beat packet. Expect framing_errors=1, packet_count=2, no further errors. Separately, omit TLAST on beat 7: framing_errors=1.
- Handshake and wrap:
  - Random TVALID gaps and pause toggling while the pattern crosses 0xFFFF→0x0000.
  - Expect zero errors and beat_count equal to the number of accepted beats.
  - Expect TREADY to follow ~pause with one-cycle lag.
- Clear and reset:
  - clear coincident with an erroneous beat: expect all counters 0 and error=0 next cycle.
  - Async reset mid-packet: expect TREADY=0 immediately, then a clean packet from the seed with zero errors.

Source files
------------

// File: rtl/data_check.sv
// Receive-side checker for the replicated 16-bit incrementing test pattern.
// Counts beats, packets and errors, and captures the first data mismatch.
module data_check #(
    parameter int DW        = 512,
    parameter int CHANNEL   = 0,
    parameter int PKT_BEATS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                pause,
    input  logic [DW-1:0]       AXIS_IN_TDATA,
    input  logic [DW/8-1:0]     AXIS_IN_TKEEP,
    input  logic                AXIS_IN_TLAST,
    input  logic                AXIS_IN_TVALID,
    output logic                AXIS_IN_TREADY,
    output logic [31:0]         beat_count,
    output logic [31:0]         packet_count,
    output logic [15:0]         data_errors,
    output logic [15:0]         framing_errors,
    output logic                error,
    output logic [15:0]         first_bad_expected,
    output logic [15:0]         first_bad_received
);

    localparam int          LANES = DW / 16;
    localparam int          IDX_W = $clog2(PKT_BEATS);
    localparam logic [15:0] SEED  = 16'((CHANNEL << 8) | CHANNEL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BEATS - 1);

    typedef enum logic {
        ST_RESET,
        ST_RUN
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_tready_next;
    logic   r_tready;

    logic [15:0]      r_expected;
    logic [IDX_W-1:0] r_beat_idx;
    logic [31:0]      r_beat_count;
    logic [31:0]      r_packet_count;
    logic [15:0]      r_data_errors;
    logic [15:0]      r_framing_errors;
    logic             r_error;
    logic [15:0]      r_first_bad_expected;
    logic [15:0]      r_first_bad_received;

    logic [LANES-1:0] w_lane_bad;
    logic [15:0]      w_first_lane;
    logic             w_keep_bad;
    logic             w_data_bad;
    logic             w_frame_bad;
    logic             w_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RESET;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_tready <= w_tready_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_tready_next = 1'b0;
        case (r_state)
            ST_RESET: w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_RESET;
        endcase
        if (w_state_next == ST_RUN) begin
            w_tready_next = ~pause;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_lane_bad[gi] = (AXIS_IN_TDATA[gi*16 +: 16] != r_expected);
        end
    endgenerate

    // Walk from the top lane down so the lowest mismatching lane wins;
    // all-ones remains when only TKEEP was wrong.
    always_comb begin
        w_first_lane = 16'hFFFF;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_lane_bad[i]) begin
                w_first_lane = AXIS_IN_TDATA[i*16 +: 16];
            end
        end
    end

    assign w_keep_bad  = (AXIS_IN_TKEEP != {(DW/8){1'b1}});
    assign w_data_bad  = (|w_lane_bad) | w_keep_bad;
    assign w_frame_bad = AXIS_IN_TLAST != (r_beat_idx == LAST_IDX);
    assign w_accept    = AXIS_IN_TVALID & r_tready;

    // Pattern tracking advances even on a cleared beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expected <= SEED;
            r_beat_idx <= '0;
        end else if (w_accept) begin
            r_expected <= AXIS_IN_TDATA[15:0] + 16'd1;
            if (AXIS_IN_TLAST) begin
                r_beat_idx <= '0;
            end else begin
                r_beat_idx <= r_beat_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_count         <= '0;
            r_packet_count       <= '0;
            r_data_errors        <= '0;
            r_framing_errors     <= '0;
            r_error              <= 1'b0;
            r_first_bad_expected <= '0;
            r_first_bad_received <= '0;
        end else if (clear) begin
            r_beat_count         <= '0;
            r_packet_count       <= '0;
            r_data_errors        <= '0;
            r_framing_errors     <= '0;
            r_error              <= 1'b0;
            r_first_bad_expected <= '0;
            r_first_bad_received <= '0;
        end else if (w_accept) begin
            r_beat_count   <= r_beat_count + 32'd1;
            r_packet_count <= r_packet_count + {31'd0, AXIS_IN_TLAST};
            if (w_data_bad) begin
                if (r_data_errors == 16'd0) begin
                    r_first_bad_expected <= r_expected;
                    r_first_bad_received <= w_first_lane;
                end
                if (r_data_errors != 16'hFFFF) begin
                    r_data_errors <= r_data_errors + 16'd1;
                end
            end
            if (w_frame_bad && (r_framing_errors != 16'hFFFF)) begin
                r_framing_errors <= r_framing_errors + 16'd1;
            end
            if (w_data_bad || w_frame_bad) begin
                r_error <= 1'b1;
            end
        end
    end

    assign AXIS_IN_TREADY     = r_tready;
    assign beat_count         = r_beat_count;
    assign packet_count       = r_packet_count;
    assign data_errors        = r_data_errors;
    assign framing_errors     = r_framing_errors;
    assign error              = r_error;
    assign first_bad_expected = r_first_bad_expected;
    assign first_bad_received = r_first_bad_received;

endmodule

// File: tb/tb_data_check.sv
// Directed bench for data_check: a reference model pushes expected
// counter snapshots per accepted beat; they are popped after the accepting edge.
module tb_data_check;

    localparam int          DW    = 128;
    localparam int          LANES = DW / 16;
    localparam logic [15:0] SEED  = 16'h0303;

    logic              clk = 1'b0;
    logic              reset, clear, pause;
    logic [DW-1:0]     tdata;
    logic [DW/8-1:0]   tkeep;
    logic              tlast, tvalid, tready;
    logic [31:0]       beat_count, packet_count;
    logic [15:0]       data_errors, framing_errors;
    logic              error;
    logic [15:0]       first_bad_expected, first_bad_received;

    data_check #(.DW(DW), .CHANNEL(3), .PKT_BEATS(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .clear              (clear),
        .pause              (pause),
        .AXIS_IN_TDATA      (tdata),
        .AXIS_IN_TKEEP      (tkeep),
        .AXIS_IN_TLAST      (tlast),
        .AXIS_IN_TVALID     (tvalid),
        .AXIS_IN_TREADY     (tready),
        .beat_count         (beat_count),
        .packet_count       (packet_count),
        .data_errors        (data_errors),
        .framing_errors     (framing_errors),
        .error              (error),
        .first_bad_expected (first_bad_expected),
        .first_bad_received (first_bad_received)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] beats;
        logic [31:0] pkts;
        logic [15:0] derr;
        logic [15:0] ferr;
        logic        err;
        logic [15:0] fbe;
        logic [15:0] fbr;
    } snap_t;

    snap_t sb[$];

    int tests = 0;
    int fails = 0;

    logic [15:0] m_exp;
    logic [2:0]  m_idx;
    logic [31:0] m_beats, m_pkts;
    logic [15:0] m_derr, m_ferr, m_fbe, m_fbr;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_beats = '0; m_pkts = '0; m_derr = '0; m_ferr = '0;
        m_err = 1'b0; m_fbe = '0; m_fbr = '0;
    endtask

    task automatic model_reset();
        model_zero();
        m_exp = SEED;
        m_idx = '0;
    endtask

    task automatic push_snap();
        snap_t s;
        s.beats = m_beats; s.pkts = m_pkts; s.derr = m_derr; s.ferr = m_ferr;
        s.err = m_err; s.fbe = m_fbe; s.fbr = m_fbr;
        sb.push_back(s);
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic keep_ok,
                                input logic last, input logic clr);
        logic        found;
        logic        dbad, fbad;
        logic [15:0] ln, fbr;
        found = 1'b0;
        fbr   = 16'hFFFF;
        for (int i = 0; i < LANES; i++) begin
            ln = d[i*16 +: 16];
            if (!found && ln != m_exp) begin
                found = 1'b1;
                fbr   = ln;
            end
        end
        dbad = found || !keep_ok;
        fbad = (last != (m_idx == 3'd7));
        if (clr) begin
            model_zero();
        end else begin
            m_beats = m_beats + 1;
            if (last) m_pkts = m_pkts + 1;
            if (dbad) begin
                if (m_derr == 16'd0) begin
                    m_fbe = m_exp;
                    m_fbr = fbr;
                end
                if (m_derr != 16'hFFFF) m_derr = m_derr + 1;
                m_err = 1'b1;
            end
            if (fbad) begin
                if (m_ferr != 16'hFFFF) m_ferr = m_ferr + 1;
                m_err = 1'b1;
            end
        end
        m_exp = d[15:0] + 16'd1;
        m_idx = last ? 3'd0 : m_idx + 3'd1;
        push_snap();
    endtask

    task automatic check_pop(input string tag);
        snap_t s;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            s = sb.pop_front();
            chk({tag, ".beat_count"}, beat_count, s.beats);
            chk({tag, ".packet_count"}, packet_count, s.pkts);
            chk({tag, ".data_errors"}, {16'd0, data_errors}, {16'd0, s.derr});
            chk({tag, ".framing_errors"}, {16'd0, framing_errors}, {16'd0, s.ferr});
            chk({tag, ".error"}, {31'd0, error}, {31'd0, s.err});
            chk({tag, ".first_bad_expected"}, {16'd0, first_bad_expected}, {16'd0, s.fbe});
            chk({tag, ".first_bad_received"}, {16'd0, first_bad_received}, {16'd0, s.fbr});
        end
    endtask

    task automatic send(input string tag, input logic [15:0] v, input int bad_lane,
                        input logic [15:0] bad_val, input logic keep_ok,
                        input logic last, input logic clr);
        logic [DW-1:0] d;
        bit            done;
        done = 1'b0;
        for (int i = 0; i < LANES; i++) d[i*16 +: 16] = (i == bad_lane) ? bad_val : v;
        @(negedge clk);
        tdata  = d;
        tkeep  = keep_ok ? {(DW/8){1'b1}} : {{(DW/8-1){1'b1}}, 1'b0};
        tlast  = last;
        tvalid = 1'b1;
        clear  = clr;
        for (int t = 0; t < 50 && !done; t++) begin
            if (tready) begin
                model_accept(d, keep_ok, last, clr);
                @(posedge clk);
                #1;
                $display("[TB] %s: data=0x%04h last=%0b keep_ok=%0b clear=%0b beats=%0d derr=%0d ferr=%0d",
                         tag, v, last, keep_ok, clr, beat_count, data_errors, framing_errors);
                check_pop(tag);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk({tag, ".accept_timeout"}, 32'd0, 32'd1);
        tvalid = 1'b0;
        clear  = 1'b0;
        tlast  = 1'b0;
        tkeep  = {(DW/8){1'b1}};
    endtask

    task automatic good(input string tag);
        send(tag, m_exp, -1, 16'h0, 1'b1, m_idx == 3'd7, 1'b0);
    endtask

    task automatic clear_only();
        @(negedge clk);
        clear = 1'b1;
        model_zero();
        push_snap();
        @(posedge clk);
        #1;
        $display("[TB] clear: beats=%0d error=%0b", beat_count, error);
        check_pop("clear");
        clear = 1'b0;
    endtask

    initial begin
        logic acc;
        reset = 1'b1; clear = 1'b0; pause = 1'b0; tvalid = 1'b0;
        tdata = '0; tkeep = {(DW/8){1'b1}}; tlast = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("reset.tready", {31'd0, tready}, 32'd0);
        push_snap();
        check_pop("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.tready_rise", {31'd0, tready}, 32'd1);

        // Clean stream: two packets from the seed.
        for (int k = 0; k < 16; k++) good("clean");
        chk("clean.total_beats", beat_count, 32'd16);
        chk("clean.total_pkts", packet_count, 32'd2);

        // Skip one value, then continue from the received value.
        good("skip_pre");
        send("skip", m_exp + 16'd1, -1, 16'h0, 1'b1, m_idx == 3'd7, 1'b0);
        for (int k = 0; k < 5; k++) good("skip_post");
        chk("skip.derr_total", {16'd0, data_errors}, 32'd1);

        // Early TLAST on beat 5, then a normal packet, then a missing TLAST.
        clear_only();
        while (m_idx != 3'd0) good("align");
        for (int k = 0; k < 6; k++)
            send("early_last", m_exp, -1, 16'h0, 1'b1, k == 5, 1'b0);
        for (int k = 0; k < 8; k++) good("after_early");
        chk("early.ferr_total", {16'd0, framing_errors}, 32'd1);
        clear_only();
        for (int k = 0; k < 8; k++) send("no_last", m_exp, -1, 16'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) good("after_no_last");
        chk("no_last.ferr_total", {16'd0, framing_errors}, 32'd1);

        // Clear coincident with a beat that fails both checks; then TKEEP-only error.
        send("clear_bad", m_exp + 16'd5, -1, 16'h0, 1'b0, m_idx != 3'd7, 1'b1);
        send("keep_bad", m_exp, -1, 16'h0, 1'b0, m_idx == 3'd7, 1'b0);
        chk("keep_bad.fbr", {16'd0, first_bad_received}, 32'h0000_FFFF);

        // Handshake and 0xFFFF wrap under random gaps and pause toggling.
        send("wrap_seed", 16'hFFEC, -1, 16'h0, 1'b1, m_idx == 3'd7, 1'b0);
        clear_only();
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            pause  = ($urandom_range(0, 3) == 0);
            tvalid = ($urandom_range(0, 3) != 0);
            tdata  = {LANES{m_exp}};
            tlast  = (m_idx == 3'd7);
            acc    = tvalid && tready;
            if (acc) model_accept({LANES{m_exp}}, 1'b1, m_idx == 3'd7, 1'b0);
            @(posedge clk);
            #1;
            $display("[TB] hs: pause=%0b valid=%0b acc=%0b tready=%0b beats=%0d",
                     pause, tvalid, acc, tready, beat_count);
            chk("hs.tready_lag", {31'd0, tready}, {31'd0, ~pause});
            if (acc) check_pop("hs");
        end
        @(negedge clk);
        pause = 1'b0; tvalid = 1'b0; tlast = 1'b0;
        @(posedge clk);
        #1;
        chk("hs.no_errors", {16'd0, data_errors}, 32'd0);

        // Async reset mid-packet, then a packet from the seed with a lane corruption at beat 3.
        good("pre_rst");
        good("pre_rst");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("[TB] async reset: tready=%0b beats=%0d", tready, beat_count);
        chk("arst.tready", {31'd0, tready}, 32'd0);
        model_reset();
        push_snap();
        check_pop("arst");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) good("from_seed");
        chk("from_seed.derr", {16'd0, data_errors}, 32'd0);
        send("lane5", m_exp, 5, m_exp + 16'd1, 1'b1, 1'b0, 1'b0);
        chk("lane5.fbe", {16'd0, first_bad_expected}, 32'h0306);
        chk("lane5.fbr", {16'd0, first_bad_received}, 32'h0307);
        for (int k = 0; k < 4; k++) good("lane5_post");
        chk("lane5.derr_total", {16'd0, data_errors}, 32'd1);
        chk("lane5.ferr_total", {16'd0, framing_errors}, 32'd0);
        chk("lane5.pkts", packet_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
